pipeline_hazard_controller: RTL and testbench

- Sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB): decides each cycle whether the PC and IF/ID register advance, which pipeline registers are flushed, and where EX operands and ID register reads are sourced.
- Keeps its own shadow pipeline of destination-register info per stage, so it needs only ID-stage decode plus redirect events.
- Handles load-use stalls (multi-cycle when data memory latency > 1), jump/jr/branch flushes, and forwarding selects.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_stage_slot.sv | 23 ++
 rtl/pipeline_hazard_controller.sv | 183 ++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forward-select codes,
// controller FSM states and the hardwired-zero register number.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int REG_ZERO = 0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  // The younger MEM result shadows WB; a load still in MEM has no data yet.
  function automatic logic [1:0] fwd_sel(input logic mem_hit,
                                         input logic mem_is_load,
                                         input logic wb_hit);
    logic [1:0] sel;
    sel = FWD_REG;
    if (mem_hit) begin
      sel = mem_is_load ? FWD_REG : FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_slot.sv
// One shadow pipeline slot: loads the upstream slot each cycle, or an
// all-zero (invalid) bubble when told to.
module hazard_stage_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forward sequencing for the 5-stage MIPS pipeline, driven from
// ID-stage decode and redirect events plus a private shadow of EX/MEM/WB.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] ID_Dest,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_Jump,
  input  logic                  EX_Jr,
  input  logic                  M_PCSrc,
  output logic                  PCWrite,
  output logic                  IFID_Write,
  output logic                  IFID_Flush,
  output logic                  IDEX_Flush,
  output logic                  EXMEM_Flush,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  ID_BypassA,
  output logic                  ID_BypassB,
  output logic                  dbg_state,
  output logic [2:0]            dbg_count
);

  // EX keeps the consumer's sources so forwarding can be resolved there.
  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memread;
    logic                  uses_rs;
    logic                  uses_rt;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
  } ex_slot_t;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memread;
    logic [REG_ADDR_W-1:0] dest;
  } mem_slot_t;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] dest;
  } wb_slot_t;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG     = REG_ADDR_W'(REG_ZERO);
  localparam logic [2:0]            STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  ex_slot_t  id_info, ex_s;
  mem_slot_t mem_d, mem_s;
  wb_slot_t  wb_d, wb_s;

  hz_state_t  state_q, state_d;
  logic [2:0] count_q, count_d;

  logic ex_load_prod, mem_prod, wb_prod, load_use;
  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

  assign id_info = '{valid: 1'b1, regwrite: ID_RegWrite, memread: ID_MemRead,
                     uses_rs: ID_UsesRs, uses_rt: ID_UsesRt, dest: ID_Dest,
                     rs: ID_Rs, rt: ID_Rt};
  assign mem_d   = '{valid: ex_s.valid, regwrite: ex_s.regwrite,
                     memread: ex_s.memread, dest: ex_s.dest};
  assign wb_d    = '{valid: mem_s.valid, regwrite: mem_s.regwrite,
                     dest: mem_s.dest};

  hazard_stage_slot #(.W($bits(ex_slot_t))) u_ex_slot (
    .clk    (Clk),
    .rst    (Reset),
    .bubble (IDEX_Flush),
    .d      (id_info),
    .q      (ex_s)
  );

  hazard_stage_slot #(.W($bits(mem_slot_t))) u_mem_slot (
    .clk    (Clk),
    .rst    (Reset),
    .bubble (EXMEM_Flush),
    .d      (mem_d),
    .q      (mem_s)
  );

  hazard_stage_slot #(.W($bits(wb_slot_t))) u_wb_slot (
    .clk    (Clk),
    .rst    (Reset),
    .bubble (1'b0),
    .d      (wb_d),
    .q      (wb_s)
  );

  // Register 0 is never a producer, so no match against it can fire.
  assign ex_load_prod = ex_s.valid && ex_s.regwrite && ex_s.memread &&
                        (ex_s.dest != ZERO_REG);
  assign mem_prod     = mem_s.valid && mem_s.regwrite && (mem_s.dest != ZERO_REG);
  assign wb_prod      = wb_s.valid && wb_s.regwrite && (wb_s.dest != ZERO_REG);

  assign load_use = ex_load_prod &&
                    ((ID_UsesRs && (ID_Rs == ex_s.dest)) ||
                     (ID_UsesRt && (ID_Rt == ex_s.dest)));

  assign mem_hit_a = mem_prod && ex_s.valid && ex_s.uses_rs && (mem_s.dest == ex_s.rs);
  assign mem_hit_b = mem_prod && ex_s.valid && ex_s.uses_rt && (mem_s.dest == ex_s.rt);
  assign wb_hit_a  = wb_prod && ex_s.valid && ex_s.uses_rs && (wb_s.dest == ex_s.rs);
  assign wb_hit_b  = wb_prod && ex_s.valid && ex_s.uses_rt && (wb_s.dest == ex_s.rt);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // The detecting cycle is the first bubble; STALL covers the remaining ones.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (M_PCSrc || EX_Jr) begin
      state_d = RUN;
      count_d = '0;
    end else if (state_q == STALL) begin
      count_d = count_q - 3'd1;
      if (count_q <= 3'd1) begin
        state_d = RUN;
        count_d = '0;
      end
    end else if (load_use && (LOAD_STALL_CYCLES > 1)) begin
      state_d = STALL;
      count_d = STALL_RELOAD;
    end
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    ForwardA    = FWD_REG;
    ForwardB    = FWD_REG;
    ID_BypassA  = 1'b0;
    ID_BypassB  = 1'b0;
    if (!Reset) begin
      ForwardA   = fwd_sel(mem_hit_a, mem_s.memread, wb_hit_a);
      ForwardB   = fwd_sel(mem_hit_b, mem_s.memread, wb_hit_b);
      ID_BypassA = wb_prod && ID_UsesRs && (ID_Rs == wb_s.dest);
      ID_BypassB = wb_prod && ID_UsesRt && (ID_Rt == wb_s.dest);
      if (M_PCSrc) begin
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        EXMEM_Flush = 1'b1;
      end else if (EX_Jr) begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if ((state_q == STALL) || load_use) begin
        PCWrite    = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end else if (ID_Jump) begin
        IFID_Flush = 1'b1;
      end
    end
  end

  assign dbg_state = state_q;
  assign dbg_count = count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (1 and 3 load bubbles)
// share one instruction stream; each cycle's expected controls go through a queue.
module tb_pipeline_hazard_controller;

  localparam int A = 5;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [A-1:0] ID_Rs, ID_Rt, ID_Dest;
  logic         ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead;
  logic         ID_Jump, EX_Jr, M_PCSrc;

  logic         pcw1, ifw1, iff1, idf1, exf1, ba1, bb1, st1;
  logic [1:0]   fa1, fb1;
  logic [2:0]   cnt1;
  logic         pcw3, ifw3, iff3, idf3, exf3, ba3, bb3, st3;
  logic [1:0]   fa3, fb3;
  logic [2:0]   cnt3;

  logic [10:0]  out1, out3;
  logic [10:0]  exp_q1[$];
  logic [10:0]  exp_q3[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, FA, FB, BypA, BypB}
  localparam logic [10:0] DEF = 11'b1_1_0_0_0_00_00_0_0;
  localparam logic [10:0] STL = 11'b0_0_0_1_0_00_00_0_0;
  localparam logic [10:0] BR  = 11'b1_1_1_1_1_00_00_0_0;
  localparam logic [10:0] JR  = 11'b1_1_1_1_0_00_00_0_0;
  localparam logic [10:0] JMP = 11'b1_1_1_0_0_00_00_0_0;

  always #5 Clk = ~Clk;

  assign out1 = {pcw1, ifw1, iff1, idf1, exf1, fa1, fb1, ba1, bb1};
  assign out3 = {pcw3, ifw3, iff3, idf3, exf3, fa3, fb3, ba3, bb3};

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .REG_ADDR_W(A)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Dest(ID_Dest),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_Jump(ID_Jump),
    .EX_Jr(EX_Jr), .M_PCSrc(M_PCSrc), .PCWrite(pcw1), .IFID_Write(ifw1),
    .IFID_Flush(iff1), .IDEX_Flush(idf1), .EXMEM_Flush(exf1),
    .ForwardA(fa1), .ForwardB(fb1), .ID_BypassA(ba1), .ID_BypassB(bb1),
    .dbg_state(st1), .dbg_count(cnt1)
  );

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .REG_ADDR_W(A)) u_dut3 (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Dest(ID_Dest),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_Jump(ID_Jump),
    .EX_Jr(EX_Jr), .M_PCSrc(M_PCSrc), .PCWrite(pcw3), .IFID_Write(ifw3),
    .IFID_Flush(iff3), .IDEX_Flush(idf3), .EXMEM_Flush(exf3),
    .ForwardA(fa3), .ForwardB(fb3), .ID_BypassA(ba3), .ID_BypassB(bb3),
    .dbg_state(st3), .dbg_count(cnt3)
  );

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] fw(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic ba, input logic bb);
    return DEF | {5'b0, fa, fb, ba, bb};
  endfunction

  task automatic set_id(input logic [A-1:0] rs, input logic [A-1:0] rt,
                        input logic urs, input logic urt, input logic [A-1:0] dest,
                        input logic rw, input logic mr);
    ID_Rs = rs; ID_Rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_Dest = dest; ID_RegWrite = rw; ID_MemRead = mr;
  endtask

  task automatic nop_id();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic lw2();   // lw $2,0($1)
    set_id(5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
  endtask

  task automatic add422(); // add $4,$2,$2
    set_id(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
  endtask

  // Inputs are applied just after a rising edge; outputs are sampled on the falling edge.
  task automatic step(input string tag, input logic [10:0] e1, input logic [10:0] e3);
    exp_q1.push_back(e1);
    exp_q3.push_back(e3);
    @(negedge Clk);
    check({tag, "/lsc1"}, out1, exp_q1.pop_front());
    check({tag, "/lsc3"}, out3, exp_q3.pop_front());
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    nop_id();
    ID_Jump = 1'b1; EX_Jr = 1'b1; M_PCSrc = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    step("rst_gated", DEF, DEF);
    ID_Jump = 1'b0; EX_Jr = 1'b0; M_PCSrc = 1'b0;
    step("rst_idle", DEF, DEF);
    check("rst_dbg3", 11'({st3, cnt3}), 11'd0);
    Reset = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); step("add3", DEF, DEF);
    set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0); step("sub_id", DEF, DEF);
    nop_id(); step("sub_ex_fwd_mem", fw(2'b01, 2'b00, 1'b0, 1'b0), fw(2'b01, 2'b00, 1'b0, 1'b0));
    nop_id(); step("drain0", DEF, DEF);

    // add $3 ; nop ; or $6,$7,$3 ; then add $8 read from ID while in WB
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); step("add3b", DEF, DEF);
    nop_id(); step("gap", DEF, DEF);
    set_id(5'd7, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); step("or_id", DEF, DEF);
    nop_id(); step("or_ex_fwd_wb", fw(2'b00, 2'b10, 1'b0, 1'b0), fw(2'b00, 2'b10, 1'b0, 1'b0));
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); step("add8", DEF, DEF);
    nop_id(); step("gap1", DEF, DEF);
    nop_id(); step("gap2", DEF, DEF);
    set_id(5'd8, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    step("id_bypass_a", fw(2'b00, 2'b00, 1'b1, 1'b0), fw(2'b00, 2'b00, 1'b1, 1'b0));
    nop_id(); step("drain1", DEF, DEF);

    // lw $2 ; add $4,$2,$2 held in ID while stalled
    lw2(); step("lw_id", DEF, DEF);
    add422(); step("luse_c0", STL, STL);
    step("luse_c1", DEF, STL);
    step("luse_c2", fw(2'b10, 2'b10, 1'b1, 1'b1), STL | 11'b11);
    nop_id(); step("luse_done", DEF, DEF);
    nop_id(); step("drain2", DEF, DEF);

    // taken branch aborts a pending stall
    lw2(); step("br_lw", DEF, DEF);
    add422(); step("br_stall", STL, STL);
    check("br_dbg3_stall", 11'({st3, cnt3}), 11'b1010);
    check("br_dbg1_run", 11'({st1, cnt1}), 11'd0);
    M_PCSrc = 1'b1; step("br_flush", BR, BR);
    check("br_dbg3_abort", 11'({st3, cnt3}), 11'd0);
    M_PCSrc = 1'b0; nop_id(); step("br_after", DEF, DEF);

    // writes to $0 never forward, bypass or stall
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0); step("add0", DEF, DEF);
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); step("use0_id", DEF, DEF);
    nop_id(); step("use0_ex", DEF, DEF);
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1); step("lw0", DEF, DEF);
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); step("lw0_nostall", DEF, DEF);
    nop_id(); step("gap3", DEF, DEF);
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0); step("wb0_nobypass", DEF, DEF);
    nop_id(); step("drain3", DEF, DEF);

    // jr in EX, and jr outranking a load-use hazard
    EX_Jr = 1'b1; step("jr", JR, JR);
    EX_Jr = 1'b0; step("jr_after", DEF, DEF);
    lw2(); step("jr_lw", DEF, DEF);
    add422(); EX_Jr = 1'b1; step("jr_over_stall", JR, JR);
    check("jr_dbg3", 11'({st3, cnt3}), 11'd0);
    EX_Jr = 1'b0; nop_id(); step("jr_after2", DEF, DEF);

    // j in ID, and stall winning over a jump
    ID_Jump = 1'b1; step("jump", JMP, JMP);
    ID_Jump = 1'b0; step("jump_after", DEF, DEF);
    lw2(); step("j_lw", DEF, DEF);
    add422(); ID_Jump = 1'b1; step("j_stall", STL, STL);
    step("j_reseen", JMP, STL);
    ID_Jump = 1'b0; nop_id();
    step("j_tail", fw(2'b10, 2'b10, 1'b0, 1'b0), STL);
    nop_id(); step("drain4", DEF, DEF);

    // reset in the middle of a 3-cycle stall
    lw2(); step("rs_lw", DEF, DEF);
    add422(); step("rs_stall", STL, STL);
    check("rs_dbg3_pre", 11'({st3, cnt3}), 11'b1010);
    Reset = 1'b1; step("rs_held", DEF, DEF);
    check("rs_dbg3_post", 11'({st3, cnt3}), 11'd0);
    Reset = 1'b0;
    set_id(5'd5, 5'd6, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0); step("rs_nodep", DEF, DEF);
    nop_id(); step("rs_nodep_ex", DEF, DEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
